mux81_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 single-bit mux (`mux81`, instantiated internally) between eight requesters.
- Grants one requester at a time for up to HOLD cycles.
- Drives the mux select in the tree's bit order.
- Returns a registered sample of the selected bit, tagged with the requester index.

---
 rtl/mux81_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_mux81_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux81_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux among eight requesters; each grant lasts up to HOLD
// cycles. Optional grant/sample counters are enabled with the MUX_ARB_STATS_EN macro.

module mux81 (
  input  logic [7:0] data_i,
  input  logic [2:0] sel_i,
  output logic       y_o
);
  logic [3:0] lvl1;
  logic [1:0] lvl2;

  // sel_i[2] steers the leaf pairs, so the index is read as {sel_i[0], sel_i[1], sel_i[2]}
  always_comb begin
    for (int i = 0; i < 4; i++) lvl1[i] = sel_i[2] ? data_i[2*i+1] : data_i[2*i];
    for (int i = 0; i < 2; i++) lvl2[i] = sel_i[1] ? lvl1[2*i+1] : lvl1[2*i];
    y_o = sel_i[0] ? lvl2[1] : lvl2[0];
  end
endmodule

module mux81_rr_arbiter #(
  parameter int unsigned HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  req,
  input  logic [7:0]  data_in,
  output logic [7:0]  grant,
  output logic [2:0]  sel,
  output logic        busy,
  output logic        out_bit,
  output logic [2:0]  out_id,
  output logic        out_valid
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt,
  output logic [15:0] sample_cnt
`endif
);
  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD - 1);

  state_e     state_q;
  logic [2:0] ptr_q, idx_q;
  logic [7:0] cnt_q;

  logic [2:0] start_idx, pick, cand;
  logic       found, end_grant, mux_y;

  function automatic logic [2:0] enc(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Scan offsets high to low so the lowest offset from start_idx wins; the
  // current owner sits at offset 7 when searching from idx_q + 1.
  always_comb begin
    start_idx = (state_q == StIdle) ? ptr_q : idx_q + 3'd1;
    found     = 1'b0;
    pick      = start_idx;
    cand      = start_idx;
    for (int i = 7; i >= 0; i--) begin
      cand = start_idx + 3'(i);
      if (req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign end_grant = (cnt_q == 8'd0) || !req[idx_q];

  mux81 u_mux (
    .data_i(data_in),
    .sel_i (sel),
    .y_o   (mux_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      grant     <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      out_bit   <= 1'b0;
      out_id    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          out_valid <= 1'b0;
          if (found) begin
            state_q <= StGrant;
            idx_q   <= pick;
            cnt_q   <= HoldLast;
            grant   <= 8'd1 << pick;
            sel     <= enc(pick);
            busy    <= 1'b1;
          end
        end
        StGrant: begin
          // A cycle whose owner has already dropped its request is not sampled.
          out_valid <= req[idx_q];
          if (req[idx_q]) begin
            out_bit <= mux_y;
            out_id  <= idx_q;
          end
          if (!end_grant) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            ptr_q <= idx_q + 3'd1;
            if (found) begin
              idx_q <= pick;
              cnt_q <= HoldLast;
              grant <= 8'd1 << pick;
              sel   <= enc(pick);
            end else begin
              state_q <= StIdle;
              grant   <= '0;
              busy    <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MUX_ARB_STATS_EN
  logic grant_start, sample_now;

  assign grant_start = found && ((state_q == StIdle) || end_grant);
  assign sample_now  = (state_q == StGrant) && req[idx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt  <= '0;
      sample_cnt <= '0;
    end else begin
      if (grant_start && (grant_cnt != 16'hFFFF)) grant_cnt <= grant_cnt + 16'd1;
      if (sample_now && (sample_cnt != 16'hFFFF)) sample_cnt <= sample_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Bench for mux81_rr_arbiter: directed vector tables, hand-written corner sequences and a
// randomized run against a behavioural model, over HOLD = 4, 2 and 1.

module tb_mux81_rr_arbiter;
  localparam int NDUT = 3;
  localparam int unsigned HV [NDUT] = '{4, 2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, data;
  logic [7:0] grant [NDUT];
  logic [2:0] sel [NDUT];
  logic [2:0] oid [NDUT];
  logic       busy [NDUT];
  logic       obit [NDUT];
  logic       oval [NDUT];
`ifdef MUX_ARB_STATS_EN
  logic [15:0] gcnt [NDUT];
  logic [15:0] scnt [NDUT];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    mux81_rr_arbiter #(.HOLD(HV[gi])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data),
      .grant     (grant[gi]),
      .sel       (sel[gi]),
      .busy      (busy[gi]),
      .out_bit   (obit[gi]),
      .out_id    (oid[gi]),
      .out_valid (oval[gi])
`ifdef MUX_ARB_STATS_EN
      ,
      .grant_cnt (gcnt[gi]),
      .sample_cnt(scnt[gi])
`endif
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         owner;
    int         used;
    int         ptr;
    int         oid;
    int         gcnt;
    int         scnt;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       ov;
    logic       ob;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t m;
    m.owner = -1; m.used = 0; m.ptr = 0; m.oid = 0; m.gcnt = 0; m.scnt = 0;
    m.grant = '0; m.sel = '0; m.busy = 1'b0; m.ov = 1'b0; m.ob = 1'b0;
    return m;
  endfunction

  function automatic int find(input logic [7:0] r, input int from);
    for (int o = 0; o < 8; o++) if (r[(from + o) % 8]) return (from + o) % 8;
    return -1;
  endfunction

  function automatic mstate_t mstart(input mstate_t m, input int k);
    mstate_t n = m;
    int s;
    s = (k % 2) * 4 + ((k / 2) % 2) * 2 + (k / 4);
    n.owner = k;
    n.used  = 0;
    n.grant = 8'(1 << k);
    n.sel   = s[2:0];
    n.busy  = 1'b1;
    if (n.gcnt < 65535) n.gcnt++;
    return n;
  endfunction

  function automatic mstate_t mnext(input mstate_t m, input int h, input logic [7:0] r,
                                    input logic [7:0] d);
    mstate_t n = m;
    int k;
    if (m.owner < 0) begin
      n.ov = 1'b0;
      k = find(r, m.ptr);
      if (k >= 0) n = mstart(n, k);
    end else begin
      k = m.owner;
      n.ov = r[k];
      if (r[k]) begin
        n.ob  = d[k];
        n.oid = k;
        if (n.scnt < 65535) n.scnt++;
      end
      n.used = m.used + 1;
      if (!r[k] || n.used >= h) begin
        n.ptr = (k + 1) % 8;
        k = find(r, n.ptr);
        if (k >= 0) n = mstart(n, k);
        else begin
          n.owner = -1;
          n.grant = '0;
          n.busy  = 1'b0;
        end
      end
    end
    return n;
  endfunction

  // ---------------- directed vectors (HOLD = 4 instance) ----------------
  typedef struct {
    bit         rst_before;
    logic [7:0] req;
    logic [7:0] data;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       valid;
    logic [2:0] id;
    logic       obit;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input bit rb, input logic [7:0] r, input logic [7:0] d, input logic [7:0] g,
                      input logic [2:0] s, input logic b, input logic v, input logic [2:0] id,
                      input logic ob);
    vec_t e;
    e.rst_before = rb; e.req = r; e.data = d; e.grant = g; e.sel = s;
    e.busy = b; e.valid = v; e.id = id; e.obit = ob;
    vecs.push_back(e);
  endtask

  // Called at a negedge; reset is pulsed and released before the next posedge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  mstate_t m [NDUT];
  int      vcount;
  logic [7:0] wrap2 [8];
  logic [7:0] wrap1 [8];

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("reset_grant_h%0d", HV[i]), grant[i], 0);
      check($sformatf("reset_sel_h%0d", HV[i]), sel[i], 0);
      check($sformatf("reset_busy_h%0d", HV[i]), busy[i], 0);
      check($sformatf("reset_valid_h%0d", HV[i]), oval[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Single persistent requester 5: continuous sampling and re-grant with no gap.
    addv(1, 8'h20, 8'h93, 8'h20, 3'b101, 1, 0, 3'd0, 0);
    for (int i = 0; i < 9; i++) addv(0, 8'h20, 8'h93, 8'h20, 3'b101, 1, 1, 3'd5, 0);
    addv(0, 8'h00, 8'h93, 8'h00, 3'b101, 0, 0, 3'd5, 0);
    addv(0, 8'h00, 8'h93, 8'h00, 3'b101, 0, 0, 3'd5, 0);
    // Early release of requester 2 hands over to 3 on the next edge.
    addv(1, 8'h0C, 8'h08, 8'h04, 3'b010, 1, 0, 3'd0, 0);
    addv(0, 8'h0C, 8'h08, 8'h04, 3'b010, 1, 1, 3'd2, 0);
    addv(0, 8'h08, 8'h08, 8'h08, 3'b110, 1, 0, 3'd2, 0);
    addv(0, 8'h08, 8'h08, 8'h08, 3'b110, 1, 1, 3'd3, 1);
    addv(0, 8'h00, 8'h08, 8'h00, 3'b110, 0, 0, 3'd3, 1);
    // One-cycle pulse of all requests: single grant to 0, then idle.
    addv(1, 8'hFF, 8'h00, 8'h01, 3'b000, 1, 0, 3'd0, 0);
    addv(0, 8'h00, 8'h00, 8'h00, 3'b000, 0, 0, 3'd0, 0);
    addv(0, 8'h00, 8'h00, 8'h00, 3'b000, 0, 0, 3'd0, 0);
    // Two requesters, full HOLD=4 each.
    addv(1, 8'h24, 8'h20, 8'h04, 3'b010, 1, 0, 3'd0, 0);
    addv(0, 8'h24, 8'h20, 8'h04, 3'b010, 1, 1, 3'd2, 0);
    addv(0, 8'h24, 8'h20, 8'h04, 3'b010, 1, 1, 3'd2, 0);
    addv(0, 8'h24, 8'h20, 8'h04, 3'b010, 1, 1, 3'd2, 0);
    addv(0, 8'h24, 8'h20, 8'h20, 3'b101, 1, 1, 3'd2, 0);
    addv(0, 8'h24, 8'h20, 8'h20, 3'b101, 1, 1, 3'd5, 1);

    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].rst_before) pulse_reset();
      req  = vecs[v].req;
      data = vecs[v].data;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_grant", v), grant[0], vecs[v].grant);
      check($sformatf("vec%0d_sel", v), sel[0], vecs[v].sel);
      check($sformatf("vec%0d_busy", v), busy[0], vecs[v].busy);
      check($sformatf("vec%0d_valid", v), oval[0], vecs[v].valid);
      if (vecs[v].valid) begin
        check($sformatf("vec%0d_id", v), oid[0], vecs[v].id);
        check($sformatf("vec%0d_bit", v), obit[0], vecs[v].obit);
      end
    end

    // Reset in the middle of a grant clears everything immediately.
    pulse_reset();
    req = 8'h01;
    data = 8'h01;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst_pre_valid", oval[0], 1);
    rst = 1'b1;
    #1;
    check("midrst_grant", grant[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_valid", oval[0], 0);
    req = 8'h00;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst_idle_grant", grant[0], 0);
    check("midrst_idle_busy", busy[0], 0);
    check("midrst_idle_valid", oval[0], 0);

    // Wrap between requesters 7 and 0 for HOLD=2 and HOLD=1.
    wrap2 = '{8'h01, 8'h01, 8'h80, 8'h80, 8'h01, 8'h01, 8'h80, 8'h80};
    wrap1 = '{8'h01, 8'h80, 8'h01, 8'h80, 8'h01, 8'h80, 8'h01, 8'h80};
    pulse_reset();
    req = 8'h81;
    data = 8'h80;
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("wrap_h2_grant%0d", c), grant[1], wrap2[c]);
      check($sformatf("wrap_h2_sel%0d", c), sel[1], (wrap2[c] == 8'h01) ? 3'b000 : 3'b111);
      check($sformatf("wrap_h1_grant%0d", c), grant[2], wrap1[c]);
      if (oval[1]) vcount++;
    end
    check("wrap_h2_valid_cycles", vcount, 7);
`ifdef MUX_ARB_STATS_EN
    check("wrap_h2_grant_cnt", gcnt[1], 4);
    check("wrap_h2_sample_cnt", scnt[1], vcount);
`endif

    // Randomized run against the model on all three instances.
    pulse_reset();
    for (int i = 0; i < NDUT; i++) m[i] = mreset();
    req = '0;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        pulse_reset();
        for (int i = 0; i < NDUT; i++) m[i] = mreset();
      end
      if ($urandom_range(15) == 0) begin
        req = 8'($urandom);
      end else if ($urandom_range(2) == 0) begin
        int b;
        b = $urandom_range(7);
        req[b] = ~req[b];
      end
      data = 8'($urandom);
      for (int i = 0; i < NDUT; i++) m[i] = mnext(m[i], int'(HV[i]), req, data);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("rnd%0d_h%0d_grant", n, HV[i]), grant[i], m[i].grant);
        check($sformatf("rnd%0d_h%0d_sel", n, HV[i]), sel[i], m[i].sel);
        check($sformatf("rnd%0d_h%0d_busy", n, HV[i]), busy[i], m[i].busy);
        check($sformatf("rnd%0d_h%0d_valid", n, HV[i]), oval[i], m[i].ov);
        check($sformatf("rnd%0d_h%0d_id", n, HV[i]), oid[i], m[i].oid);
        check($sformatf("rnd%0d_h%0d_bit", n, HV[i]), obit[i], m[i].ob);
`ifdef MUX_ARB_STATS_EN
        check($sformatf("rnd%0d_h%0d_gcnt", n, HV[i]), gcnt[i], m[i].gcnt);
        check($sformatf("rnd%0d_h%0d_scnt", n, HV[i]), scnt[i], m[i].scnt);
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
